// File: rtl/flash_cmd_ctrl.sv
// flash_cmd_ctrl: sequences SPI flash read/program/erase commands into driver ops with WREN and status polling
module flash_cmd_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_POLL_MAX = 100000,
  parameter int P_PAGE_MAX = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_cmd_type,
  input  logic [23:0]             i_cmd_addr,
  input  logic [15:0]             i_cmd_len,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  output logic                    o_done,
  output logic                    o_error,
  output logic [P_DATA_WIDTH-1:0] o_status,
  input  logic [P_DATA_WIDTH-1:0] i_wr_data,
  output logic                    o_wr_req,
  output logic [P_DATA_WIDTH-1:0] o_rd_data,
  output logic                    o_rd_valid,
  output logic [31:0]             o_op_data,
  output logic [1:0]              o_op_type,
  output logic [15:0]             o_op_len,
  output logic [15:0]             o_clk_len,
  output logic                    o_op_valid,
  input  logic                    i_op_ready,
  input  logic                    i_drv_write_req,
  output logic [P_DATA_WIDTH-1:0] o_drv_write_data,
  input  logic [P_DATA_WIDTH-1:0] i_drv_read_data,
  input  logic                    i_drv_read_valid
);
  typedef enum logic [3:0] {IDLE, CHECK, WREN, CMD, POLL, WAIT_OP, EVAL, DONE, ERR} state_t;
  typedef enum logic [1:0] {PH_WREN, PH_CMD, PH_POLL} phase_t;
  state_t state, state_n;
  phase_t ph;
  logic [1:0] typ;
  logic [23:0] addr;
  logic [15:0] len;
  logic seen_low;
  logic [31:0] poll_cnt;
  logic bad_len, in_cmd, in_poll, in_rd, wr_en;
  assign bad_len = (len == 16'd0 && !typ[1]) || (typ == 2'd1 && 32'(len) > P_PAGE_MAX) ||
                   (typ == 2'd0 && len > 16'd4092);
  assign in_cmd = state == CMD || (state == WAIT_OP && ph == PH_CMD);
  assign in_poll = state == POLL || (state == WAIT_OP && ph == PH_POLL);
  assign in_rd = in_cmd && typ == 2'd0;
  assign wr_en = in_cmd && typ == 2'd1;
  assign o_cmd_ready = state == IDLE;
  assign o_done = state == DONE;
  assign o_error = state == ERR;
  assign o_op_valid = state == WREN || state == CMD || state == POLL;
  assign o_wr_req = wr_en && i_drv_write_req;
  assign o_drv_write_data = wr_en ? i_wr_data : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_cmd_valid ? CHECK : IDLE;
      CHECK:   state_n = bad_len ? ERR : typ == 2'd0 ? CMD : WREN;
      WREN, CMD, POLL: state_n = i_op_ready ? WAIT_OP : state;
      WAIT_OP: state_n = !(i_op_ready && seen_low) ? WAIT_OP : ph == PH_WREN ? CMD :
                         ph == PH_POLL ? EVAL : typ == 2'd0 ? DONE : POLL;
      EVAL:    state_n = !o_status[0] ? DONE : poll_cnt < 32'(P_POLL_MAX) ? POLL : ERR;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_op_data = '0;
    o_op_type = '0;
    o_op_len = '0;
    o_clk_len = '0;
    case (state)
      WREN: begin
        o_op_data = 32'h0600_0000;
        o_op_len = 16'd8;
        o_clk_len = 16'd8;
      end
      POLL: begin
        o_op_data = 32'h0500_0000;
        o_op_type = 2'd2;
        o_op_len = 16'd8;
        o_clk_len = 16'd16;
      end
      CMD: begin
        o_op_data = typ == 2'd0 ? {8'h03, addr} : typ == 2'd1 ? {8'h02, addr} :
                    typ == 2'd2 ? {8'h20, addr} : 32'hC700_0000;
        o_op_type = typ == 2'd0 ? 2'd2 : typ == 2'd1 ? 2'd1 : 2'd0;
        o_op_len = typ == 2'd3 ? 16'd8 : 16'd32;
        o_clk_len = typ[1] ? (typ[0] ? 16'd8 : 16'd32) : 16'd32 + {len[12:0], 3'b000};
      end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      ph <= PH_WREN;
      typ <= '0;
      addr <= '0;
      len <= '0;
      seen_low <= 1'b0;
      poll_cnt <= '0;
      o_status <= '0;
      o_rd_data <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && i_cmd_valid) begin
        typ <= i_cmd_type;
        addr <= i_cmd_addr;
        len <= i_cmd_len;
        poll_cnt <= '0;
      end
      if (o_op_valid && i_op_ready) begin
        ph <= state == WREN ? PH_WREN : state == CMD ? PH_CMD : PH_POLL;
        seen_low <= 1'b0;
        if (state == POLL) poll_cnt <= poll_cnt + 32'd1;
      end else if (state == WAIT_OP && !i_op_ready) seen_low <= 1'b1;
      if (in_poll && i_drv_read_valid) o_status <= i_drv_read_data;
      if (in_rd && i_drv_read_valid) o_rd_data <= i_drv_read_data;
      o_rd_valid <= in_rd && i_drv_read_valid;
    end
  end
endmodule
